// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;

   // Bit-counter width for a given slot width; never narrower than one bit.
   function automatic int bit_cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shifter assembling one slot word, MSB first.
// Latency: word_o is combinational from din_i, so a word is ready on its final beat.
// Backpressure: none; shifts only when shift_i is high, clr_i discards history.
module sipo_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             shift_i,
   input  logic             din_i,
   output logic [WIDTH-1:0] word_o
);

   // Only WIDTH-1 bits are stored; the last bit joins straight from din_i.
   logic [WIDTH-2:0] sr_q;
   logic [WIDTH-2:0] sr_d;

   assign word_o = {sr_q, din_i};

   // Next shift-register value: clear+shift loads din as the first bit of a fresh word.
   always_comb begin
      sr_d = sr_q;
      if (clr_i && shift_i) begin
         sr_d    = '0;
         sr_d[0] = din_i;
      end else if (clr_i) begin
         sr_d = '0;
      end else if (shift_i) begin
         sr_d = word_o[WIDTH-2:0];
      end
   end

   // Shift-register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule

// File: rtl/demux1to4_tdm.sv
// Splits a serial 4-slot TDM stream into four WIDTH-bit channel words.
// Latency: Yk and ch_valid[k] appear one cycle after the slot's final valid bit.
// Backpressure: none; din_valid=0 cycles freeze all framing state.
module demux1to4_tdm
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [WIDTH-1:0]  Y0,
   output logic [WIDTH-1:0]  Y1,
   output logic [WIDTH-1:0]  Y2,
   output logic [WIDTH-1:0]  Y3,
   output logic [NUM_CH-1:0] ch_valid,
   output logic              frame_done,
   output logic              sync_err
);

   localparam int               BC_W     = bit_cnt_w(WIDTH);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
   localparam logic [BC_W-1:0]  ONE_BIT  = BC_W'(1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

   state_t              state_q;
   logic [BC_W-1:0]     bit_cnt_q;
   logic [SLOT_W-1:0]   slot_cnt_q;
   logic [WIDTH-1:0]    y_q [NUM_CH];
   logic [NUM_CH-1:0]   ch_valid_q;
   logic                frame_done_q;
   logic                sync_err_q;

   logic                frame_start;
   logic                sr_clr;
   logic                sr_shift;
   logic [WIDTH-1:0]    word;

   // The only beat where frame_sync is mandatory in RUN.
   assign frame_start = (bit_cnt_q == '0) && (slot_cnt_q == '0);

   // Shifter control: any sync beat starts a fresh word, a missing sync drops history.
   always_comb begin
      sr_clr   = 1'b0;
      sr_shift = 1'b0;
      if (din_valid) begin
         if (frame_sync) begin
            sr_clr   = 1'b1;
            sr_shift = 1'b1;
         end else if (state_q == RUN) begin
            if (frame_start) begin
               sr_clr = 1'b1;
            end else begin
               sr_shift = 1'b1;
            end
         end
      end
   end

   sipo_shift #(
      .WIDTH (WIDTH)
   ) u_sipo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (sr_clr),
      .shift_i (sr_shift),
      .din_i   (din),
      .word_o  (word)
   );

   // Framing FSM, slot/bit counters, channel registers and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         bit_cnt_q    <= '0;
         slot_cnt_q   <= '0;
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            y_q[k] <= '0;
         end
      end else begin
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         if (din_valid) begin
            case (state_q)
               HUNT: begin
                  if (frame_sync) begin
                     state_q    <= RUN;
                     slot_cnt_q <= '0;
                     bit_cnt_q  <= ONE_BIT;
                  end
               end
               RUN: begin
                  if (frame_start && !frame_sync) begin
                     // Lost alignment: drop the beat and resynchronise.
                     sync_err_q <= 1'b1;
                     state_q    <= HUNT;
                     slot_cnt_q <= '0;
                     bit_cnt_q  <= '0;
                  end else if (frame_sync) begin
                     // Sync off the expected position abandons the partial slot.
                     sync_err_q <= !frame_start;
                     slot_cnt_q <= '0;
                     bit_cnt_q  <= ONE_BIT;
                  end else if (bit_cnt_q == LAST_BIT) begin
                     y_q[slot_cnt_q] <= word;
                     ch_valid_q      <= NUM_CH'(1) << slot_cnt_q;
                     frame_done_q    <= (slot_cnt_q == LAST_SLOT);
                     bit_cnt_q       <= '0;
                     slot_cnt_q      <= slot_cnt_q + 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign Y0         = y_q[0];
   assign Y1         = y_q[1];
   assign Y2         = y_q[2];
   assign Y3         = y_q[3];
   assign ch_valid   = ch_valid_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Scoreboard bench for demux1to4_tdm with WIDTH=8.
// Latency: expects every strobe exactly one cycle after the beat that causes it.
// Backpressure: none; the driver inserts din_valid gaps to exercise stalls.
module tb_demux1to4_tdm;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         din;
   logic         din_valid;
   logic         frame_sync;
   logic [W-1:0] y0, y1, y2, y3;
   logic [3:0]   ch_valid;
   logic         frame_done;
   logic         sync_err;

   typedef struct {
      bit         is_err;
      int         ch;
      logic [7:0] word;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   demux1to4_tdm #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .Y0         (y0),
      .Y1         (y1),
      .Y2         (y2),
      .Y3         (y3),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [7:0] y_of(input int ch);
      case (ch)
         0:       return y0;
         1:       return y1;
         2:       return y2;
         default: return y3;
      endcase
   endfunction

   // Monitor: any strobe activity must match the oldest expected event, on time.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (ch_valid != 4'b0 || sync_err || frame_done)) begin
         check("onehot", 32'($countones(ch_valid) <= 1), 32'd1);
         if (exp_q.size() == 0) begin
            check("unexpected_output", {26'd0, ch_valid, frame_done, sync_err}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("due_cycle", cyc, mon_e.due);
            if (mon_e.is_err) begin
               check("sync_err", {26'd0, ch_valid, frame_done, sync_err}, 32'd1);
            end else begin
               check("ch_valid", {28'd0, ch_valid}, 32'd1 << mon_e.ch);
               check("frame_done", {31'd0, frame_done}, {31'd0, mon_e.ch == 3});
               check($sformatf("Y%0d", mon_e.ch), {24'd0, y_of(mon_e.ch)}, {24'd0, mon_e.word});
            end
         end
      end
   end

   task automatic idle();
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      din        = 1'($urandom_range(0, 1));
      frame_sync = 1'($urandom_range(0, 1));
   endtask

   task automatic beat(input logic b, input logic fs);
      @(posedge clk);
      #1;
      din_valid  = 1'b1;
      din        = b;
      frame_sync = fs;
   endtask

   task automatic push_word(input int ch, input logic [7:0] w);
      exp_q.push_back('{is_err: 1'b0, ch: ch, word: w, due: cyc + 1});
   endtask

   task automatic push_err();
      exp_q.push_back('{is_err: 1'b1, ch: 0, word: 8'h00, due: cyc + 1});
   endtask

   // gap: 0 none, 1 idle before every beat, 2 random idles.
   task automatic send_word(input int slot, input logic [7:0] w, input int gap, input bit err_first);
      for (int i = W - 1; i >= 0; i--) begin
         if (gap == 1 || (gap == 2 && $urandom_range(0, 7) == 0)) idle();
         beat(w[i], (slot == 0 && i == W - 1));
         if (err_first && i == W - 1) push_err();
         if (i == 0) push_word(slot, w);
      end
   endtask

   task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [7:0] w3, input int gap, input bit err_first);
      send_word(0, w0, gap, err_first);
      send_word(1, w1, gap, 1'b0);
      send_word(2, w2, gap, 1'b0);
      send_word(3, w3, gap, 1'b0);
   endtask

   task automatic check_outputs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
      check({tag, "_Y0"}, {24'd0, y0}, {24'd0, e0});
      check({tag, "_Y1"}, {24'd0, y1}, {24'd0, e1});
      check({tag, "_Y2"}, {24'd0, y2}, {24'd0, e2});
      check({tag, "_Y3"}, {24'd0, y3}, {24'd0, e3});
   endtask

   task automatic check_zero(input string tag);
      check_outputs(tag, 8'h00, 8'h00, 8'h00, 8'h00);
      check({tag, "_strobes"}, {26'd0, ch_valid, frame_done, sync_err}, 32'd0);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] r0, r1, r2, r3;
      din        = 1'b0;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      rst_n      = 1'b1;
      #2 rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // Unsynchronised bits are ignored in HUNT.
      for (int i = 0; i < 12; i++) beat(i[0], 1'b0);

      // Clean frame, then the same frame with a gap before every beat.
      send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 1'b0);
      idle(); idle();
      check_outputs("frame1", 8'hA5, 8'h3C, 8'hFF, 8'h01);
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0);
      send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1, 1'b0);
      idle(); idle();
      check_outputs("gapped", 8'hA5, 8'h3C, 8'hFF, 8'h01);

      // Missing sync at the next frame start: error, then silence until resync.
      pat = 8'h6B;
      for (int i = 0; i < 4 * W; i++) begin
         if (i % 5 == 2) idle();
         beat(pat[i % W], 1'b0);
         if (i == 0) push_err();
      end
      idle(); idle();
      check_outputs("hunt_hold", 8'hA5, 8'h3C, 8'hFF, 8'h01);
      send_frame(8'h0F, 8'hF0, 8'hAA, 8'h55, 0, 1'b0);

      // Early sync at slot 2 bit 3 abandons the partial slot.
      send_word(0, 8'h12, 0, 1'b0);
      send_word(1, 8'h34, 0, 1'b0);
      pat = 8'h56;
      beat(pat[7], 1'b0);
      beat(pat[6], 1'b0);
      beat(pat[5], 1'b0);
      send_word(0, 8'h9A, 0, 1'b1);
      idle();
      check("Y2_held", {24'd0, y2}, 32'hAA);
      send_word(1, 8'hBC, 0, 1'b0);
      send_word(2, 8'hDE, 0, 1'b0);
      send_word(3, 8'hF0, 0, 1'b0);
      idle(); idle();
      check_outputs("resync", 8'h9A, 8'hBC, 8'hDE, 8'hF0);

      // Asynchronous reset in the middle of slot 1.
      send_word(0, 8'h11, 0, 1'b0);
      pat = 8'h22;
      beat(pat[7], 1'b0);
      beat(pat[6], 1'b0);
      beat(pat[5], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) beat(1'b1, 1'b0);
      send_frame(8'hC3, 8'h5A, 8'h69, 8'h96, 0, 1'b0);
      idle(); idle();
      check_outputs("post_reset", 8'hC3, 8'h5A, 8'h69, 8'h96);

      // Random frames with random valid gaps.
      for (int f = 0; f < 1000; f++) begin
         r0 = 8'($urandom_range(0, 255));
         r1 = 8'($urandom_range(0, 255));
         r2 = 8'($urandom_range(0, 255));
         r3 = 8'($urandom_range(0, 255));
         send_frame(r0, r1, r2, r3, 2, 1'b0);
      end

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle();
      idle(); idle();
      check("drain", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux1to4_tdm.md
DEMUX1TO4_TDM -- requirements
Module: demux1to4_tdm

Interface
REQ-001 Parameter WIDTH, default 8, sets the bits per channel slot (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 din  input  1  serial TDM data bit, MSB of each slot first.
REQ-005 din_valid  input  1  qualifies din and frame_sync; when low, the cycle is ignored.
REQ-006 frame_sync  input  1  marks the first bit (MSB) of slot 0; meaningful only with din_valid=1.
REQ-007 Y0, Y1, Y2, Y3  output  WIDTH each  last completed word of channel 0..3.
REQ-008 ch_valid  output  4  one-cycle strobe; bit k means Yk updated this cycle.
REQ-009 frame_done  output  1  one-cycle strobe when slot 3 completes.
REQ-010 sync_err  output  1  one-cycle strobe on framing violation.

Function
REQ-011 States: HUNT (unsynchronised) and RUN; reset state is HUNT.
REQ-012 Each frame carries slots 0,1,2,3 of WIDTH bits each, back to back: 4*WIDTH valid bits per frame.
REQ-013 A beat is a cycle with din_valid=1; cycles with din_valid=0 change no counter, shift register or state.
REQ-014 In HUNT, beats with frame_sync=0 are discarded with no output activity.
REQ-015 In HUNT, a beat with frame_sync=1 shall load din as bit 0 of slot 0, set slot_cnt=0 and bit_cnt=1, and enter RUN.
REQ-016 In RUN, each beat shifts din into the shift register (MSB first) and increments bit_cnt.
REQ-017 On the beat where bit_cnt reaches WIDTH-1, the assembled word goes to Y[slot_cnt]; ch_valid[slot_cnt]=1 the next cycle (latency 1 cycle from the last bit).
REQ-018 On that beat, bit_cnt wraps to 0 and slot_cnt increments modulo 4 (3 wraps to 0).
REQ-019 frame_done shall pulse in the same cycle as ch_valid[3].
REQ-020 In RUN, frame_sync=1 on the expected frame-start beat (slot_cnt=0, bit_cnt=0) is required, and the beat is accepted normally.
REQ-021 In RUN, frame_sync=0 on the expected frame-start beat shall pulse sync_err the next cycle, discard the beat, and enter HUNT.
REQ-022 In RUN, frame_sync=1 on any other beat shall pulse sync_err the next cycle and abandon the partial slot (no Y update or ch_valid for it). The beat becomes bit 0 of slot 0 and the block stays in RUN.
REQ-023 Y0..Y3 hold their values between updates and are never updated with a partial word.
REQ-024 At most one ch_valid bit shall be high in any cycle.
REQ-025 ch_valid, frame_done and sync_err are registered outputs with no combinational path from inputs.

Reset
REQ-026 When rst_n=0, Y0..Y3=0, ch_valid=0, frame_done=0, sync_err=0, bit_cnt=0, slot_cnt=0, shift register=0 and state=HUNT, immediately and without a clock edge.
REQ-027 Reset mid-frame discards all partial data; after release, the block requires a fresh frame_sync.
REQ-028 Release of rst_n is synchronised externally; the first edge after release may accept a beat.

Structure
REQ-029 Shared package demux_pkg holds the state enum (HUNT, RUN), NUM_CH=4, and the slot-counter width constant.
REQ-030 One sub-module, sipo_shift (WIDTH-bit serial-in/parallel-out with shift enable and clear), holds the datapath; the control FSM and counters live in demux1to4_tdm.
REQ-031 The RTL is synthesizable with no latches.

Verification (WIDTH=8)
REQ-032 Continuous valid frame with words A5,3C,FF,01 and frame_sync on the first bit -> Y0=A5, Y1=3C, Y2=FF, Y3=01; ch_valid strobes 0001,0010,0100,1000 one cycle after each slot's 8th bit; frame_done with the last strobe.
REQ-033 Same frame with din_valid low on every other cycle -> identical Y values and strobe order; each strobe comes one cycle after that slot's final valid beat.
REQ-034 Two frames, with frame_sync absent at the second frame start -> sync_err pulse, state HUNT, no further ch_valid until the next frame_sync; Y keeps the first frame's values.
REQ-035 frame_sync reasserted at slot 2, bit 3 -> sync_err pulse, no Y2 update. The following 32 bits decode as a full new frame (Y0..Y3 correct).
REQ-036 rst_n pulsed low during slot 1 -> all outputs 0 asynchronously. Bits after release are discarded until frame_sync; the next frame decodes correctly.
REQ-037 Random frames for 1000 frames against a reference model -> no mismatch, and never more than one ch_valid bit high.
